// File: rtl/comparator_int_pipe.sv
// Multi-lane integer comparator with a STAGES-deep stall-able pipeline.
// Each lane evaluates a runtime-selected relation between din1 and din2 and reports the wrapped difference.
module comparator_int_pipe #(
    parameter int WIDTH  = 24,
    parameter int LANES  = 4,
    parameter int STAGES = 2,
    parameter int SIGNED = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*WIDTH-1:0]   din1,
    input  logic [LANES*WIDTH-1:0]   din2,
    input  logic [2:0]               op,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES-1:0]         comp_out,
    output logic [LANES*WIDTH-1:0]   diff,
    output logic [2:0]               op_out
);

    localparam int LW = LANES * WIDTH;

    // One extra bit makes the subtraction exact for both signed and unsigned operands.
    function automatic logic signed [WIDTH:0] extend(input logic [WIDTH-1:0] v);
        if (SIGNED != 0)
            return {v[WIDTH-1], v};
        else
            return {1'b0, v};
    endfunction

    function automatic logic relate(input logic [2:0] rel, input logic eq, input logic lt);
        case (rel)
            3'd0:    return lt | eq;
            3'd1:    return lt;
            3'd2:    return eq;
            3'd3:    return ~eq;
            3'd4:    return ~lt;
            3'd5:    return ~lt & ~eq;
            default: return 1'b0;
        endcase
    endfunction

    logic             adv;
    logic [LANES-1:0] res_in;
    logic [LW-1:0]    diff_in;

    logic [STAGES-1:0] vld_p;
    logic [2:0]        op_p   [STAGES];
    logic [LANES-1:0]  res_p  [STAGES];
    logic [LW-1:0]     diff_p [STAGES];

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // Input side: combinational per-lane compare feeding stage 0
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic signed [WIDTH:0] d_ext;
        assign d_ext = extend(din1[i*WIDTH +: WIDTH]) - extend(din2[i*WIDTH +: WIDTH]);
        assign diff_in[i*WIDTH +: WIDTH] = d_ext[WIDTH-1:0];
        assign res_in[i] = relate(op, d_ext == '0, d_ext[WIDTH]);
    end

    // Stage 0 .. STAGES-1: whole pipe shifts together on adv; bubbles shift too
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
            for (int s = 0; s < STAGES; s++) begin
                op_p[s]   <= '0;
                res_p[s]  <= '0;
                diff_p[s] <= '0;
            end
        end else if (adv) begin
            vld_p[0]  <= in_valid;
            op_p[0]   <= op;
            res_p[0]  <= res_in;
            diff_p[0] <= diff_in;
            for (int s = 1; s < STAGES; s++) begin
                vld_p[s]  <= vld_p[s-1];
                op_p[s]   <= op_p[s-1];
                res_p[s]  <= res_p[s-1];
                diff_p[s] <= diff_p[s-1];
            end
        end
    end

    // Output: last stage drives the ports directly
    assign out_valid = vld_p[STAGES-1];
    assign comp_out  = res_p[STAGES-1];
    assign diff      = diff_p[STAGES-1];
    assign op_out    = op_p[STAGES-1];

endmodule

// File: tb/tb_comparator_int_pipe.sv
// Randomised bench for comparator_int_pipe: a signed and an unsigned instance share all inputs
// and are checked against an integer-arithmetic reference model through an in-order scoreboard.
module tb_comparator_int_pipe;

    localparam int WIDTH  = 24;
    localparam int LANES  = 4;
    localparam int STAGES = 2;
    localparam int LW     = LANES * WIDTH;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b1;
    logic [LW-1:0]     din1 = '0;
    logic [LW-1:0]     din2 = '0;
    logic [2:0]        op = '0;
    logic              in_ready, in_ready_u;
    logic              out_valid, out_valid_u;
    logic [LANES-1:0]  comp_out, comp_out_u;
    logic [LW-1:0]     diff, diff_u;
    logic [2:0]        op_out, op_out_u;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [2:0]    op;
        logic [LW-1:0] a;
        logic [LW-1:0] b;
    } txn_t;

    typedef struct packed {
        logic             ok;
        logic [2:0]       op;
        logic [LANES-1:0] cs;
        logic [LANES-1:0] cu;
        logic [LW-1:0]    d;
    } exp_t;

    txn_t exp_q[$];

    comparator_int_pipe #(.WIDTH(WIDTH), .LANES(LANES), .STAGES(STAGES), .SIGNED(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .din1(din1), .din2(din2), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .comp_out(comp_out), .diff(diff), .op_out(op_out)
    );

    comparator_int_pipe #(.WIDTH(WIDTH), .LANES(LANES), .STAGES(STAGES), .SIGNED(0)) dut_u (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_u),
        .din1(din1), .din2(din2), .op(op), .out_valid(out_valid_u), .out_ready(out_ready),
        .comp_out(comp_out_u), .diff(diff_u), .op_out(op_out_u)
    );

    always #5 clk = ~clk;

    // Reference: operands as plain integers, relations with ordinary comparison operators
    function automatic logic [LANES-1:0] model_comp(input logic [2:0] o, input logic [LW-1:0] x,
                                                    input logic [LW-1:0] y, input bit sg);
        logic [LANES-1:0] r;
        longint a, b;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            a = longint'(x[i*WIDTH +: WIDTH]);
            b = longint'(y[i*WIDTH +: WIDTH]);
            if (sg && a >= (longint'(1) << (WIDTH-1))) a = a - (longint'(1) << WIDTH);
            if (sg && b >= (longint'(1) << (WIDTH-1))) b = b - (longint'(1) << WIDTH);
            case (o)
                3'd0:    r[i] = (a <= b);
                3'd1:    r[i] = (a <  b);
                3'd2:    r[i] = (a == b);
                3'd3:    r[i] = (a != b);
                3'd4:    r[i] = (a >= b);
                3'd5:    r[i] = (a >  b);
                default: r[i] = 1'b0;
            endcase
        end
        return r;
    endfunction

    function automatic logic [LW-1:0] model_diff(input logic [LW-1:0] x, input logic [LW-1:0] y);
        logic [LW-1:0] r;
        longint d;
        for (int i = 0; i < LANES; i++) begin
            d = longint'(x[i*WIDTH +: WIDTH]) - longint'(y[i*WIDTH +: WIDTH]);
            r[i*WIDTH +: WIDTH] = d[WIDTH-1:0];
        end
        return r;
    endfunction

    function automatic exp_t pop_expect();
        exp_t e;
        txn_t t;
        e = 'x;
        e.ok = 1'b0;
        if (exp_q.size() > 0) begin
            t = exp_q.pop_front();
            e.ok = 1'b1;
            e.op = t.op;
            e.cs = model_comp(t.op, t.a, t.b, 1'b1);
            e.cu = model_comp(t.op, t.a, t.b, 1'b0);
            e.d  = model_diff(t.a, t.b);
        end
        return e;
    endfunction

    function automatic logic [LW-1:0] rand_operand();
        logic [LW-1:0] v;
        for (int i = 0; i < LANES; i++) begin
            case ($urandom_range(0, 5))
                0:       v[i*WIDTH +: WIDTH] = '0;
                1:       v[i*WIDTH +: WIDTH] = {1'b0, {(WIDTH-1){1'b1}}};
                2:       v[i*WIDTH +: WIDTH] = {1'b1, {(WIDTH-1){1'b0}}};
                3:       v[i*WIDTH +: WIDTH] = '1;
                default: v[i*WIDTH +: WIDTH] = WIDTH'($urandom);
            endcase
        end
        return v;
    endfunction

    // Drives one cycle of inputs and logs the transaction if the DUT accepts it
    task automatic step(input logic iv, input logic [2:0] o, input logic [LW-1:0] a,
                        input logic [LW-1:0] b, input logic ordy);
        @(negedge clk);
        in_valid  = iv;
        op        = o;
        din1      = a;
        din2      = b;
        out_ready = ordy;
        #1;
        if (iv && in_ready) exp_q.push_back('{o, a, b});
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step(1'b1, 3'($urandom_range(0, 7)), rand_operand(), rand_operand(), 1'b1);
            n_cmp++;
            if ({out_valid, out_valid_u, comp_out, comp_out_u, diff, diff_u, op_out} !== '0) begin
                n_bad++;
                $display("FAIL reset_hold: out_valid=%0b comp_out=%h diff=%h required all zero",
                         out_valid, comp_out, diff);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 3'd0, '0, '0, 1'b1);
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_idle: out_valid=%0b required 0", out_valid);
            end
        end
        step(1'b1, 3'd2, rand_operand(), rand_operand(), 1'b1);
        for (int c = 1; c <= STAGES; c++) begin
            step(1'b0, 3'd0, '0, '0, 1'b1);
            n_cmp++;
            if (out_valid !== (c == STAGES)) begin
                n_bad++;
                $display("FAIL reset_first_latency: cycle %0d out_valid=%0b required %0b",
                         c, out_valid, c == STAGES);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_latency();
        logic [LW-1:0] a, b;
        exp_t e;
        a = rand_operand();
        b = rand_operand();
        a[WIDTH-1:0] = 24'd5;
        b[WIDTH-1:0] = 24'd9;
        step(1'b1, 3'd0, a, b, 1'b1);
        for (int c = 1; c <= STAGES + 1; c++) begin
            step(1'b0, 3'd0, '0, '0, 1'b1);
            n_cmp++;
            if (out_valid !== (c == STAGES)) begin
                n_bad++;
                $display("FAIL latency_valid: cycle %0d out_valid=%0b required %0b",
                         c, out_valid, c == STAGES);
            end
            if (c == STAGES) begin
                n_cmp++;
                if ({comp_out[0], diff[WIDTH-1:0]} !== {1'b1, 24'hFFFFFC}) begin
                    n_bad++;
                    $display("FAIL latency_value: comp0=%0b diff0=%h required 1 fffffc",
                             comp_out[0], diff[WIDTH-1:0]);
                end
                e = pop_expect();
                n_cmp++;
                if ({out_valid_u, comp_out, comp_out_u, diff, diff_u, op_out} !==
                    {e.ok, e.cs, e.cu, e.d, e.d, e.op}) begin
                    n_bad++;
                    $display("FAIL latency_lanes: comp=%h/%h diff=%h required %h/%h %h",
                             comp_out, comp_out_u, diff, e.cs, e.cu, e.d);
                end
            end
        end
    endtask

    task automatic test_ops_sweep();
        logic [7:0] seq;
        logic [LW-1:0] v;
        int k;
        exp_t e;
        seq = 8'b0001_0101;
        v = {LANES{24'h000010}};
        k = 0;
        for (int c = 0; c < 8 + STAGES + 1; c++) begin
            if (c < 8) step(1'b1, 3'(c), v, v, 1'b1);
            else       step(1'b0, 3'd0, '0, '0, 1'b1);
            if (out_valid && out_ready) begin
                n_cmp++;
                if ({comp_out[0], diff, op_out} !== {seq[k], {LW{1'b0}}, 3'(k)}) begin
                    n_bad++;
                    $display("FAIL ops_sweep: op=%0d comp0=%0b diff=%h required %0b 0",
                             op_out, comp_out[0], diff, seq[k]);
                end
                e = pop_expect();
                n_cmp++;
                if ({out_valid_u, comp_out, comp_out_u} !== {e.ok, e.cs, e.cu}) begin
                    n_bad++;
                    $display("FAIL ops_sweep_lanes: comp=%h/%h required %h/%h",
                             comp_out, comp_out_u, e.cs, e.cu);
                end
                k++;
            end
        end
        n_cmp++;
        if (k != 8) begin
            n_bad++;
            $display("FAIL ops_sweep_count: got %0d results required 8", k);
        end
    endtask

    task automatic test_overflow();
        logic [LW-1:0] a, b;
        a = {LANES{24'h7FFFFF}};
        b = {LANES{24'h800000}};
        step(1'b1, 3'd5, a, b, 1'b1);
        for (int c = 0; c < STAGES; c++) step(1'b0, 3'd0, '0, '0, 1'b1);
        n_cmp++;
        if ({out_valid, comp_out, comp_out_u, diff} !== {1'b1, 4'hF, 4'h0, {LANES{24'hFFFFFF}}}) begin
            n_bad++;
            $display("FAIL overflow: valid=%0b signed=%h unsigned=%h diff=%h required 1 f 0 ffffff..",
                     out_valid, comp_out, comp_out_u, diff);
        end
        exp_q.delete();
        step(1'b0, 3'd0, '0, '0, 1'b1);
    endtask

    task automatic test_backpressure();
        logic [LW-1:0] da [6];
        logic [LW-1:0] held;
        logic [LANES-1:0] held_c;
        logic prev_stall;
        int idx, got;
        exp_t e;
        for (int i = 0; i < 6; i++) da[i] = rand_operand();
        idx = 0;
        got = 0;
        prev_stall = 1'b0;
        held = '0;
        held_c = '0;
        for (int c = 0; c < 40 && !(got == 6 && idx == 6); c++) begin
            step(idx < 6, 3'(idx % 6), da[idx % 6], da[(idx + 3) % 6], !(c >= 2 && c < 5));
            if (in_valid && in_ready) idx++;
            if (prev_stall) begin
                n_cmp++;
                if ({out_valid, comp_out, diff} !== {1'b1, held_c, held}) begin
                    n_bad++;
                    $display("FAIL bp_hold: valid=%0b comp=%h diff=%h required 1 %h %h",
                             out_valid, comp_out, diff, held_c, held);
                end
            end
            prev_stall = out_valid && !out_ready;
            if (prev_stall) begin
                held = diff;
                held_c = comp_out;
                n_cmp++;
                if (in_ready !== 1'b0) begin
                    n_bad++;
                    $display("FAIL bp_in_ready: in_ready=%0b required 0", in_ready);
                end
            end
            if (out_valid && out_ready) begin
                e = pop_expect();
                got++;
                n_cmp++;
                if ({e.ok, out_valid_u, comp_out, comp_out_u, diff, diff_u, op_out} !==
                    {2'b11, e.cs, e.cu, e.d, e.d, e.op}) begin
                    n_bad++;
                    $display("FAIL bp_order: op=%0d comp=%h diff=%h required %0d %h %h",
                             op_out, comp_out, diff, e.op, e.cs, e.d);
                end
            end
        end
        n_cmp++;
        if (got != 6 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL bp_count: got %0d pending %0d required 6 0", got, exp_q.size());
        end
    endtask

    task automatic test_random_stream();
        logic [LW-1:0] a, b;
        exp_t e;
        for (int c = 0; c < 300; c++) begin
            a = rand_operand();
            b = ($urandom_range(0, 3) == 0) ? a : rand_operand();
            step(c < 290 && $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), a, b,
                 c >= 290 || $urandom_range(0, 2) != 0);
            if (out_valid && out_ready) begin
                e = pop_expect();
                n_cmp++;
                if ({e.ok, out_valid_u, comp_out, comp_out_u, diff, diff_u, op_out} !==
                    {2'b11, e.cs, e.cu, e.d, e.d, e.op}) begin
                    n_bad++;
                    $display("FAIL random: op=%0d comp=%h/%h diff=%h required %0d %h/%h %h",
                             op_out, comp_out, comp_out_u, diff, e.op, e.cs, e.cu, e.d);
                end
            end
        end
        n_cmp++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL random_drain: pending %0d out_valid=%0b required 0 0", exp_q.size(), out_valid);
        end
    endtask

    task automatic test_reset_midstream();
        step(1'b1, 3'd3, rand_operand(), rand_operand(), 1'b1);
        step(1'b1, 3'd4, rand_operand(), rand_operand(), 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, out_valid_u, comp_out, diff, op_out} !== '0) begin
            n_bad++;
            $display("FAIL midreset_clear: valid=%0b comp=%h diff=%h required 0", out_valid, comp_out, diff);
        end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < STAGES + 3; c++) begin
            step(1'b0, 3'd0, '0, '0, 1'b1);
            n_cmp++;
            if ({out_valid, out_valid_u} !== 2'b00) begin
                n_bad++;
                $display("FAIL midreset_ghost: cycle %0d out_valid=%0b required 0", c, out_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_ops_sweep();
        test_overflow();
        test_backpressure();
        test_random_stream();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
